// File: rtl/pipe_pkg.sv
// Shared definitions for the in-order core's pipeline-boundary registers.
// Holds the bubble encoding, default field widths and the {pc4, inst} payload type.
package pipe_pkg;

    localparam int          PC_W_DEF   = 32;
    localparam int          INST_W_DEF = 32;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W_DEF-1:0]   pc4;
        logic [INST_W_DEF-1:0] inst;
    } pipe_beat_t;

    function automatic pipe_beat_t bubble_beat();
        pipe_beat_t b;
        b.pc4  = '0;
        b.inst = NOP_INST;
        return b;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle for one pipeline-stage register.
// The slave modport is the stage itself; the master modport is the surrounding environment.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int INST_W = INST_W_DEF
);

    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [PC_W-1:0]   in_pc4_i;
    logic [INST_W-1:0] in_inst_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [PC_W-1:0]   out_pc4_o;
    logic [INST_W-1:0] out_inst_o;

    modport slave (
        input  flush_i, in_valid_i, in_pc4_i, in_inst_i, out_ready_i,
        output in_ready_o, out_valid_o, out_pc4_o, out_inst_o
    );

    modport master (
        output flush_i, in_valid_i, in_pc4_i, in_inst_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_pc4_o, out_inst_o
    );

endinterface

// File: rtl/pipe_skid_buf.sv
// Single skid entry with its own valid bit; clear takes priority over load.
// Only instantiated when PIPE_STAGE_SKID_EN is defined.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int W = PC_W_DEF + INST_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register carrying {pc4, inst} with stall and flush-to-bubble.
// Define PIPE_STAGE_SKID_EN to add a skid entry so in_ready_o comes from a flop.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                PC_W     = PC_W_DEF,
    parameter int                INST_W   = INST_W_DEF,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(pipe_pkg::NOP_INST)
) (
    input logic               clk,
    input logic               rst_n,
    pipe_stage_reg_if.slave   bus
);

    logic [PC_W-1:0]        r_pc4;
    logic [INST_W-1:0]      r_inst;
    logic                   w_outValid;
    logic                   w_inReady;
    logic                   w_accept;
    logic                   w_emit;
    logic                   w_mainLoad;
    logic                   w_mainClear;
    logic [PC_W+INST_W-1:0] w_mainData;

    assign w_accept = bus.in_valid_i & w_inReady;
    assign w_emit   = w_outValid & bus.out_ready_i;

`ifdef PIPE_STAGE_SKID_EN
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_nextState;
    logic                   w_skidLoad;
    logic                   w_skidClear;
    logic                   w_skidValid;
    logic [PC_W+INST_W-1:0] w_skidData;

    pipe_skid_buf #(.W(PC_W + INST_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skidLoad),
        .i_clear (w_skidClear),
        .i_data  ({bus.in_pc4_i, bus.in_inst_i}),
        .o_valid (w_skidValid),
        .o_data  (w_skidData)
    );

    // Ready depends only on the skid flop (and flush), never on out_ready_i.
    assign w_inReady  = ~w_skidValid | bus.flush_i;
    assign w_outValid = (r_state != ST_EMPTY);

    always_comb begin
        w_nextState = r_state;
        w_skidLoad  = 1'b0;
        w_skidClear = bus.flush_i;
        w_mainLoad  = 1'b0;
        w_mainClear = bus.flush_i;
        w_mainData  = {bus.in_pc4_i, bus.in_inst_i};
        if (bus.flush_i) begin
            w_nextState = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_nextState = ST_ONE;
                        w_mainLoad  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_emit) begin
                        w_mainLoad = 1'b1;
                    end else if (w_accept) begin
                        w_nextState = ST_TWO;
                        w_skidLoad  = 1'b1;
                    end else if (w_emit) begin
                        w_nextState = ST_EMPTY;
                        w_mainClear = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (w_emit) begin
                        w_nextState = ST_ONE;
                        w_skidClear = 1'b1;
                        w_mainLoad  = 1'b1;
                        w_mainData  = w_skidData;
                    end
                end
                default: begin
                    w_nextState = ST_EMPTY;
                    w_mainClear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end
`else
    logic r_valid;

    assign w_inReady   = ~r_valid | bus.out_ready_i | bus.flush_i;
    assign w_outValid  = r_valid;
    assign w_mainLoad  = w_accept;
    assign w_mainClear = bus.flush_i | (w_emit & ~w_accept);
    assign w_mainData  = {bus.in_pc4_i, bus.in_inst_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (w_mainClear) begin
            r_valid <= 1'b0;
        end else if (w_mainLoad) begin
            r_valid <= 1'b1;
        end
    end
`endif

    // Payload is forced to the bubble whenever the stage is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc4  <= '0;
            r_inst <= NOP_INST;
        end else if (w_mainClear) begin
            r_pc4  <= '0;
            r_inst <= NOP_INST;
        end else if (w_mainLoad) begin
            r_pc4  <= w_mainData[PC_W+INST_W-1:INST_W];
            r_inst <= w_mainData[INST_W-1:0];
        end
    end

    assign bus.in_ready_o  = w_inReady;
    assign bus.out_valid_o = w_outValid;
    assign bus.out_pc4_o   = r_pc4;
    assign bus.out_inst_o  = r_inst;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed stall/flush/reset cases, then random traffic.
// Honours PIPE_STAGE_SKID_EN to pick the stage capacity of the reference model.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk;
    logic rst_n;
    int   checkCount;
    int   passCount;
    logic expReady;
    pipe_beat_t sb[$];

    pipe_stage_reg_if #(.PC_W(32), .INST_W(32)) bus ();

    pipe_stage_reg #(.PC_W(32), .INST_W(32), .NOP_INST(32'h0000_0013)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic compareVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the visible stage against the model and retires emitted beats.
    task automatic checkOutput();
        pipe_beat_t b;
        if (!rst_n) begin
            sb.delete();
            expReady = 1'b0;
            return;
        end
        if (CAP == 2) expReady = bus.flush_i || (sb.size() < 2);
        else          expReady = bus.flush_i || (sb.size() == 0) || bus.out_ready_i;
        compareVal("in_ready", {63'd0, bus.in_ready_o}, {63'd0, expReady});
        compareVal("out_valid", {63'd0, bus.out_valid_o}, {63'd0, sb.size() != 0});
        b = (sb.size() != 0) ? sb[0] : bubble_beat();
        compareVal("out_pc4", {32'd0, bus.out_pc4_o}, {32'd0, b.pc4});
        compareVal("out_inst", {32'd0, bus.out_inst_o}, {32'd0, b.inst});
        if (bus.flush_i) sb.delete();
        else if (sb.size() != 0 && bus.out_ready_i) void'(sb.pop_front());
    endtask

    always begin
        @(negedge clk);
        #3;
        checkOutput();
    end

    // Driver: presents one cycle of stimulus and records any beat the model says is taken.
    task automatic applyStimulus(input logic valid, input logic [31:0] pc4, input logic [31:0] inst,
                                 input logic outReady, input logic flush);
        pipe_beat_t b;
        @(negedge clk);
        bus.in_valid_i  = valid;
        bus.in_pc4_i    = pc4;
        bus.in_inst_i   = inst;
        bus.out_ready_i = outReady;
        bus.flush_i     = flush;
        #4;
        if (rst_n && valid && expReady && !flush) begin
            b.pc4  = pc4;
            b.inst = inst;
            sb.push_back(b);
        end
    endtask

    initial begin
        checkCount       = 0;
        passCount        = 0;
        expReady         = 1'b0;
        rst_n            = 1'b0;
        bus.in_valid_i   = 1'b0;
        bus.in_pc4_i     = '0;
        bus.in_inst_i    = '0;
        bus.out_ready_i  = 1'b0;
        bus.flush_i      = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        compareVal("reset_valid", {63'd0, bus.out_valid_o}, 64'd0);
        compareVal("reset_inst", {32'd0, bus.out_inst_o}, 64'h13);
        compareVal("reset_pc4", {32'd0, bus.out_pc4_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compareVal("ready_after_reset", {63'd0, bus.in_ready_o}, 64'd1);

        $display("[TB] streaming");
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 32'(i * 4), $urandom, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        $display("[TB] stall then flush");
        applyStimulus(1'b1, 32'h100, 32'h0050_0093, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h104 + 32'(i * 4), 32'h0060_0113, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h200, 32'h0070_0193, 1'b0, 1'b1);
        repeat (2) applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        $display("[TB] skid ordering");
        applyStimulus(1'b1, 32'h300, 32'hAAAA_0013, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h304, 32'hBBBB_0013, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h308, 32'hCCCC_0013, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 32'h400, 32'h0080_0213, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        compareVal("midreset_valid", {63'd0, bus.out_valid_o}, 64'd0);
        compareVal("midreset_inst", {32'd0, bus.out_inst_o}, 64'h13);
        compareVal("midreset_pc4", {32'd0, bus.out_pc4_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compareVal("ready_after_midreset", {63'd0, bus.in_ready_o}, 64'd1);

        $display("[TB] random traffic");
        for (int i = 0; i < 10000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end
        repeat (4) applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        compareVal("drain_left", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
